// File: rtl/rs_pool.sv
// Shared-pool reservation station: dispatch into the lowest free entry, CDB wakeup, one issue per FU class.
// Latency: a dispatched ready entry is offered the cycle after the dispatch edge; a wakeup at edge N allows issue in cycle N.
// Backpressure: disp_ready=~full from registered state; a held (iss_ready=0) entry is re-offered and stays allocated.
module rs_pool #(
    parameter int RS_DEPTH = 8,
    parameter int NUM_FU   = 5,
    parameter int NUM_CDB  = 2,
    parameter int TAG_W    = 6,
    parameter int OP_W     = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               disp_valid,
    output logic                               disp_ready,
    input  logic [$clog2(NUM_FU)-1:0]          disp_fu,
    input  logic [OP_W-1:0]                    disp_op,
    input  logic [TAG_W-1:0]                   disp_t,
    input  logic [1:0]                         disp_s_used,
    input  logic [2*TAG_W-1:0]                 disp_s_tag,
    input  logic [1:0]                         disp_s_rdy,
    input  logic [NUM_CDB-1:0]                 cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]           cdb_tag,
    output logic [NUM_FU-1:0]                  iss_valid,
    input  logic [NUM_FU-1:0]                  iss_ready,
    output logic [NUM_FU*OP_W-1:0]             iss_op,
    output logic [NUM_FU*TAG_W-1:0]            iss_t,
    output logic [NUM_FU*2*TAG_W-1:0]          iss_s_tag,
    output logic [$clog2(RS_DEPTH+1)-1:0]      free_count,
    output logic                               full,
    output logic                               empty
);
    localparam int FU_W  = $clog2(NUM_FU);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = $clog2(RS_DEPTH+1);

    logic [RS_DEPTH-1:0]  busy;
    logic [1:0]           src_rdy [RS_DEPTH];
    logic [FU_W-1:0]      e_fu    [RS_DEPTH];
    logic [OP_W-1:0]      e_op    [RS_DEPTH];
    logic [TAG_W-1:0]     e_t     [RS_DEPTH];
    logic [2*TAG_W-1:0]   e_src   [RS_DEPTH];

    logic [RS_DEPTH-1:0]  elig;
    logic [RS_DEPTH-1:0]  issue_clr;
    logic [IDX_W-1:0]     sel [NUM_FU];
    logic [IDX_W-1:0]     alloc_idx;
    logic                 disp_fire;
    logic [1:0]           wr_rdy;
    logic [CNT_W-1:0]     free_cnt;

    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag,
                                     input logic [NUM_CDB-1:0] vld,
                                     input logic [NUM_CDB*TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++)
            if (vld[k] && tags[k*TAG_W +: TAG_W] == tag) hit = 1'b1;
        return hit;
    endfunction

    // Select looks only at registered entry state, so no input reaches the issue outputs.
    always_comb begin
        iss_valid = '0;
        iss_op    = '0;
        iss_t     = '0;
        iss_s_tag = '0;
        issue_clr = '0;
        for (int i = 0; i < RS_DEPTH; i++)
            elig[i] = busy[i] & (&src_rdy[i]);
        for (int f = 0; f < NUM_FU; f++) begin
            sel[f] = '0;
            for (int i = RS_DEPTH-1; i >= 0; i--) begin
                if (elig[i] && e_fu[i] == FU_W'(f)) begin
                    iss_valid[f] = 1'b1;
                    sel[f]       = IDX_W'(i);
                end
            end
            iss_op[f*OP_W +: OP_W]           = e_op[sel[f]];
            iss_t[f*TAG_W +: TAG_W]          = e_t[sel[f]];
            iss_s_tag[f*2*TAG_W +: 2*TAG_W]  = e_src[sel[f]];
            if (iss_valid[f] && iss_ready[f])
                issue_clr[sel[f]] = 1'b1;
        end
    end

    always_comb begin
        alloc_idx = '0;
        free_cnt  = '0;
        for (int i = RS_DEPTH-1; i >= 0; i--) begin
            if (!busy[i]) alloc_idx = IDX_W'(i);
            free_cnt = free_cnt + CNT_W'(!busy[i]);
        end
    end

    assign free_count = free_cnt;
    assign full       = (free_cnt == '0);
    assign empty      = (free_cnt == CNT_W'(RS_DEPTH));
    assign disp_ready = ~full;
    assign disp_fire  = disp_valid && disp_ready && ({1'b0, disp_fu} < (FU_W+1)'(NUM_FU));

    // Same-cycle CDB bypass so a new entry never misses a broadcast of its source.
    always_comb begin
        for (int j = 0; j < 2; j++)
            wr_rdy[j] = ~disp_s_used[j] | disp_s_rdy[j]
                      | cdb_hit(disp_s_tag[j*TAG_W +: TAG_W], cdb_valid, cdb_tag);
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            busy <= '0;
            for (int i = 0; i < RS_DEPTH; i++) src_rdy[i] <= 2'b00;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (issue_clr[i]) busy[i] <= 1'b0;
                for (int j = 0; j < 2; j++)
                    if (busy[i] && cdb_hit(e_src[i][j*TAG_W +: TAG_W], cdb_valid, cdb_tag))
                        src_rdy[i][j] <= 1'b1;
            end
            if (disp_fire) begin
                busy[alloc_idx]    <= 1'b1;
                src_rdy[alloc_idx] <= wr_rdy;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (disp_fire) begin
            e_fu[alloc_idx]  <= disp_fu;
            e_op[alloc_idx]  <= disp_op;
            e_t[alloc_idx]   <= disp_t;
            e_src[alloc_idx] <= disp_s_tag;
        end
    end
endmodule

// File: tb/tb_rs_pool.sv
// Randomized and directed stimulus for rs_pool, checked against a behavioural pool model.
module tb_rs_pool;
    localparam int RS_DEPTH = 8;
    localparam int NUM_FU   = 5;
    localparam int NUM_CDB  = 2;
    localparam int TAG_W    = 6;
    localparam int OP_W     = 32;

    logic                          clock = 1'b0;
    logic                          reset, flush, disp_valid, disp_ready;
    logic [2:0]                    disp_fu;
    logic [OP_W-1:0]               disp_op;
    logic [TAG_W-1:0]              disp_t;
    logic [1:0]                    disp_s_used, disp_s_rdy;
    logic [2*TAG_W-1:0]            disp_s_tag;
    logic [NUM_CDB-1:0]            cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]      cdb_tag;
    logic [NUM_FU-1:0]             iss_valid, iss_ready;
    logic [NUM_FU*OP_W-1:0]        iss_op;
    logic [NUM_FU*TAG_W-1:0]       iss_t;
    logic [NUM_FU*2*TAG_W-1:0]     iss_s_tag;
    logic [3:0]                    free_count;
    logic                          full, empty;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the pool: one record per slot.
    bit               m_busy [RS_DEPTH];
    int               m_fu   [RS_DEPTH];
    logic [OP_W-1:0]  m_op   [RS_DEPTH];
    logic [TAG_W-1:0] m_t    [RS_DEPTH];
    logic [TAG_W-1:0] m_s1   [RS_DEPTH];
    logic [TAG_W-1:0] m_s2   [RS_DEPTH];
    bit               m_r1   [RS_DEPTH];
    bit               m_r2   [RS_DEPTH];

    rs_pool dut (
        .clock(clock), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_fu(disp_fu),
        .disp_op(disp_op), .disp_t(disp_t), .disp_s_used(disp_s_used),
        .disp_s_tag(disp_s_tag), .disp_s_rdy(disp_s_rdy),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_t(iss_t), .iss_s_tag(iss_s_tag),
        .free_count(free_count), .full(full), .empty(empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit broadcast(input logic [TAG_W-1:0] tag);
        bit hit = 0;
        for (int k = 0; k < NUM_CDB; k++)
            if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag) hit = 1;
        return hit;
    endfunction

    function automatic int oldest_ready(input int f);
        for (int i = 0; i < RS_DEPTH; i++)
            if (m_busy[i] && m_r1[i] && m_r2[i] && m_fu[i] == f) return i;
        return -1;
    endfunction

    function automatic int n_free();
        int n = 0;
        for (int i = 0; i < RS_DEPTH; i++) if (!m_busy[i]) n++;
        return n;
    endfunction

    function automatic logic [TAG_W-1:0] port_t(input int f);
        return iss_t[f*TAG_W +: TAG_W];
    endfunction

    task automatic model_update();
        int pick [NUM_FU];
        int slot;
        if (reset || flush) begin
            for (int i = 0; i < RS_DEPTH; i++) m_busy[i] = 0;
            return;
        end
        for (int f = 0; f < NUM_FU; f++) pick[f] = oldest_ready(f);
        slot = -1;
        for (int i = RS_DEPTH-1; i >= 0; i--) if (!m_busy[i]) slot = i;
        for (int i = 0; i < RS_DEPTH; i++) if (m_busy[i]) begin
            if (broadcast(m_s1[i])) m_r1[i] = 1;
            if (broadcast(m_s2[i])) m_r2[i] = 1;
        end
        for (int f = 0; f < NUM_FU; f++)
            if (pick[f] >= 0 && iss_ready[f]) m_busy[pick[f]] = 0;
        if (disp_valid && slot >= 0 && int'(disp_fu) < NUM_FU) begin
            m_busy[slot] = 1;
            m_fu[slot]   = int'(disp_fu);
            m_op[slot]   = disp_op;
            m_t[slot]    = disp_t;
            m_s1[slot]   = disp_s_tag[TAG_W-1:0];
            m_s2[slot]   = disp_s_tag[2*TAG_W-1:TAG_W];
            m_r1[slot]   = !disp_s_used[0] || disp_s_rdy[0] || broadcast(m_s1[slot]);
            m_r2[slot]   = !disp_s_used[1] || disp_s_rdy[1] || broadcast(m_s2[slot]);
        end
    endtask

    task automatic check_outputs();
        logic [NUM_FU-1:0] ev = '0;
        int p;
        for (int f = 0; f < NUM_FU; f++) begin
            p = oldest_ready(f);
            if (p >= 0) begin
                ev[f] = 1'b1;
                check($sformatf("iss_t[%0d]", f), 64'(port_t(f)), 64'(m_t[p]));
                check($sformatf("iss_op[%0d]", f), 64'(iss_op[f*OP_W +: OP_W]), 64'(m_op[p]));
                check($sformatf("iss_s_tag[%0d]", f), 64'(iss_s_tag[f*2*TAG_W +: 2*TAG_W]),
                      64'({m_s2[p], m_s1[p]}));
            end
        end
        check("iss_valid", 64'(iss_valid), 64'(ev));
        check("free_count", 64'(free_count), 64'(n_free()));
        check("full", 64'(full), 64'(n_free() == 0));
        check("empty", 64'(empty), 64'(n_free() == RS_DEPTH));
        check("disp_ready", 64'(disp_ready), 64'(n_free() != 0));
    endtask

    task automatic tick();
        model_update();
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle();
        flush = 0; disp_valid = 0; cdb_valid = '0; cdb_tag = '0;
    endtask

    task automatic set_disp(input int fu, input int t, input int s1, input int s2,
                            input logic [1:0] used, input logic [1:0] rdy);
        disp_valid  = 1;
        disp_fu     = 3'(fu);
        disp_t      = TAG_W'(t);
        disp_op     = 32'hA5A0_0000 | 32'(t);
        disp_s_tag  = {TAG_W'(s2), TAG_W'(s1)};
        disp_s_used = used;
        disp_s_rdy  = rdy;
    endtask

    initial begin
        reset = 1; idle(); iss_ready = '0;
        disp_fu = '0; disp_op = '0; disp_t = '0; disp_s_used = '0; disp_s_tag = '0; disp_s_rdy = '0;
        for (int i = 0; i < RS_DEPTH; i++) m_busy[i] = 0;
        tick(); tick();
        reset = 0;
        check("rst free_count", 64'(free_count), 64'd8);
        check("rst empty", 64'(empty), 64'd1);
        check("rst full", 64'(full), 64'd0);
        check("rst iss_valid", 64'(iss_valid), 64'd0);

        // ALU op with ready sources, then issue
        set_disp(0, 5, 0, 0, 2'b00, 2'b00); tick();
        idle();
        check("alu valid", 64'(iss_valid[0]), 64'd1);
        check("alu t", 64'(port_t(0)), 64'd5);
        iss_ready = 5'b00001; tick();
        check("alu freed", 64'(free_count), 64'd8);

        // FP1 waiting on tag 9: no same-cycle CDB-to-issue
        iss_ready = '0;
        set_disp(3, 7, 9, 0, 2'b01, 2'b00); tick();
        idle(); cdb_valid = 2'b10; cdb_tag = {TAG_W'(9), TAG_W'(0)};
        check("fp1 before wake", 64'(iss_valid[3]), 64'd0);
        tick(); idle();
        check("fp1 after wake", 64'(iss_valid[3]), 64'd1);
        iss_ready = '1; tick();

        // Dispatch bypass from a same-cycle broadcast of tag 12
        iss_ready = '0;
        set_disp(0, 3, 12, 0, 2'b01, 2'b00);
        cdb_valid = 2'b01; cdb_tag = {TAG_W'(0), TAG_W'(12)};
        tick(); idle();
        check("bypass valid", 64'(iss_valid[0]), 64'd1);
        iss_ready = '1; tick(); tick();
        check("drained", 64'(empty), 64'd1);

        // Fill the pool behind tag 20
        iss_ready = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            set_disp(i % NUM_FU, i, 20, 0, 2'b01, 2'b00); tick();
        end
        check("fill full", 64'(full), 64'd1);
        check("fill disp_ready", 64'(disp_ready), 64'd0);
        set_disp(0, 40, 0, 0, 2'b00, 2'b00); tick();
        check("ninth ignored", 64'(free_count), 64'd0);
        idle(); iss_ready = '1; cdb_valid = 2'b01; cdb_tag = {TAG_W'(0), TAG_W'(20)};
        tick(); idle();
        check("wake all valid", 64'(iss_valid), 64'h1f);
        check("wake alu first", 64'(port_t(0)), 64'd0);
        tick();
        check("second round valid", 64'(iss_valid), 64'h07);
        check("second alu", 64'(port_t(0)), 64'd5);
        tick();
        check("all issued", 64'(empty), 64'd1);

        // Hold: ALU entries at idx 1 and 3, port 0 stalled
        iss_ready = '0;
        set_disp(4, 10, 30, 0, 2'b01, 2'b00); tick();
        set_disp(0, 11, 0, 0, 2'b00, 2'b00);  tick();
        set_disp(4, 12, 30, 0, 2'b01, 2'b00); tick();
        set_disp(0, 13, 0, 0, 2'b00, 2'b00);  tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            check("hold t", 64'(port_t(0)), 64'd11);
            check("hold no free", 64'(free_count), 64'd4);
        end
        iss_ready = 5'b00001; tick();
        check("then idx3", 64'(port_t(0)), 64'd13);
        tick();
        check("alu done", 64'(iss_valid[0]), 64'd0);

        // Flush with 5 busy and a same-cycle dispatch
        iss_ready = '0;
        for (int i = 0; i < 3; i++) begin
            set_disp(1, 20 + i, 30, 0, 2'b01, 2'b00); tick();
        end
        check("five busy", 64'(free_count), 64'd3);
        set_disp(0, 33, 0, 0, 2'b00, 2'b00); flush = 1; iss_ready = '1;
        tick(); idle();
        check("flush empty", 64'(empty), 64'd1);
        check("flush free", 64'(free_count), 64'd8);
        check("flush iss_valid", 64'(iss_valid), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            disp_valid  = ($urandom_range(0, 3) != 0);
            disp_fu     = 3'($urandom_range(0, 6));
            disp_op     = $urandom;
            disp_t      = TAG_W'($urandom);
            disp_s_used = 2'($urandom);
            disp_s_rdy  = 2'($urandom_range(0, 3) == 0 ? 3 : 0);
            disp_s_tag  = {TAG_W'($urandom_range(0, 15)), TAG_W'($urandom_range(0, 15))};
            cdb_valid   = NUM_CDB'($urandom);
            cdb_tag     = {TAG_W'($urandom_range(0, 15)), TAG_W'($urandom_range(0, 15))};
            iss_ready   = NUM_FU'($urandom);
            flush       = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
